mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single 256-bit external memory interface (`ext_mem_*`) between the instruction-side and data-side L1 caches of the pipelined CPU. It accepts one line-sized read or write request at a time and grants the requesters round-robin. It registers the transaction onto the memory bus, waits for `ext_mem_ack`, and returns a one-cycle ack with read data to the owner. An optional watchdog aborts transactions that the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 256, cache-line / memory data width
- TIMEOUT, 64, watchdog limit in BUSY cycles (≥2); used only with the macro
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_addr  in  ADDR_W  I-side line address
- i_data_i  in  DATA_W  I-side write data
- i_cs  in  1  I-side request valid; held with addr/data/we stable until i_ack
- i_we  in  1  I-side write (1) / read (0)
- i_data_o  out  DATA_W  I-side read data, valid while i_ack=1
- i_ack  out  1  I-side completion pulse, one cycle
- i_err  out  1  I-side timeout flag, qualifies i_ack
- d_addr, d_data_i, d_cs, d_we, d_data_o, d_ack, d_err: same as I-side, for the D-side
- ext_mem_addr  out  ADDR_W  registered memory address
- ext_mem_data_o  out  DATA_W  registered memory write data
- ext_mem_cs  out  1  memory enable
- ext_mem_we  out  1  memory write
- ext_mem_data_i  in  DATA_W  memory read data, valid with ext_mem_ack
- ext_mem_ack  in  1  memory completion
- grant_d  out  1  current/last owner: 1 = D, 0 = I

## Operation
- States: IDLE, BUSY, RESP. Registers: owner, last_owner, err_r, timeout counter.
- IDLE:
  - If no cs is asserted, stay in IDLE.
  - If exactly one cs is asserted, grant that side.
  - If both are asserted, grant the side that is not last_owner.
  - On grant: latch the owner's addr/we/data_i into the ext_mem_* registers, set ext_mem_cs=1, go to BUSY, and set last_owner=owner.
- BUSY:
  - ext_mem_cs, ext_mem_we, ext_mem_addr and ext_mem_data_o stay constant.
  - On ext_mem_ack=1: capture ext_mem_data_i into the owner's data_o (writes capture too; the value is don't-care), clear ext_mem_cs/we, and go to RESP.
  - The non-owner's cs is ignored and stays pending.
- RESP:
  - The owner's ack=1 for exactly one cycle; err=err_r.
  - Next state is always IDLE, so there is no back-to-back grant without an IDLE cycle.
  - Requesters drop or replace cs at the edge ending RESP.
- data_o holds its value after ack until the next completion for that side.
- A write and a read are arbitrated identically; there is no reordering and at most one outstanding transaction.
- ext_mem_ack outside BUSY is ignored.

## Timing
- Reset (async, immediate):
  - State IDLE, last_owner=I (D wins the first tie).
  - All outputs 0, including ext_mem_cs, ack, err, data_o and grant_d.
- Reset mid-BUSY: ext_mem_cs drops asynchronously, the transaction is lost, no ack is issued, and a later ext_mem_ack is ignored.
- Request sampled at edge E0 (IDLE) → ext_mem_cs=1 in cycle after E0.
- ext_mem_ack sampled at edge Ek → owner ack in cycle after Ek.
- Minimum latency (ack in the first BUSY cycle): cs seen → ack 2 cycles later. Request-to-request throughput is memory latency + 2 cycles.
- grant_d updates at the grant edge and holds through RESP and the following IDLE.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - The counter clears on grant and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT-1 and ext_mem_ack=0: drop ext_mem_cs, set err_r=1, load owner data_o=0, and go to RESP. The owner then sees ack=1, err=1.
  - If ack and the limit occur in the same cycle, ack wins and err=0.
- MEM_ARB_TIMEOUT_EN not defined: no counter; BUSY waits indefinitely; i_err and d_err are tied 0.

## Test plan
- Single read: d_cs=1, d_addr=0x100, d_we=0; memory acks 3 cycles after cs with 0xA5…A5 → ext_mem_addr=0x100, ext_mem_cs high for 3 cycles, d_ack pulses once with d_data_o=0xA5…A5, and i_ack stays 0.
- Tie after reset: i_cs=d_cs=1 in the same cycle → D served first (grant_d=1), then I. With both held asserted across 4 transactions, the grant order is D, I, D, I.
- Write: i_cs=1, i_we=1, i_addr=0x40, i_data_i=0x1234 → ext_mem_we=1, ext_mem_data_o=0x1234 throughout BUSY, and i_ack a single cycle after ext_mem_ack.
- Zero-wait memory: ext_mem_ack tied high → ack exactly 2 cycles after cs is sampled. The requester re-asserts cs at the edge ending RESP, so grants are 3 cycles apart.
- Reset mid-operation: rst low during BUSY → ext_mem_cs=0 immediately. After reset release, a stray ext_mem_ack produces no ack, and the next request proceeds normally.
- Timeout (macro on, TIMEOUT=8): memory never acks → ext_mem_cs drops after 8 BUSY cycles and d_ack=1 with d_err=1, d_data_o=0. With the macro off, ext_mem_cs stays high for ≥100 cycles with no ack.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two cache-side requesters and the external memory port.
// The master modport is the arbiter's view; slave is the environment (caches + memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data_i;
    logic              i_cs;
    logic              i_we;
    logic [DATA_W-1:0] i_data_o;
    logic              i_ack;
    logic              i_err;

    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_i;
    logic              d_cs;
    logic              d_we;
    logic [DATA_W-1:0] d_data_o;
    logic              d_ack;
    logic              d_err;

    logic [ADDR_W-1:0] ext_mem_addr;
    logic [DATA_W-1:0] ext_mem_data_o;
    logic              ext_mem_cs;
    logic              ext_mem_we;
    logic [DATA_W-1:0] ext_mem_data_i;
    logic              ext_mem_ack;

    logic              grant_d;

    modport master (
        input  i_addr, i_data_i, i_cs, i_we,
        input  d_addr, d_data_i, d_cs, d_we,
        input  ext_mem_data_i, ext_mem_ack,
        output i_data_o, i_ack, i_err,
        output d_data_o, d_ack, d_err,
        output ext_mem_addr, ext_mem_data_o, ext_mem_cs, ext_mem_we,
        output grant_d
    );

    modport slave (
        output i_addr, i_data_i, i_cs, i_we,
        output d_addr, d_data_i, d_cs, d_we,
        output ext_mem_data_i, ext_mem_ack,
        input  i_data_o, i_ack, i_err,
        input  d_data_o, d_ack, d_err,
        input  ext_mem_addr, ext_mem_data_o, ext_mem_cs, ext_mem_we,
        input  grant_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-side and D-side caches.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts unacknowledged transactions.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    logic   owner;   // 1 = D; also remembered as last owner for tie-breaks
    logic   sel_d;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mem_arbiter: TIMEOUT must be at least 2");
    end

    // On a tie the side that did not win last time gets the port.
    assign sel_d       = bus.d_cs && (!bus.i_cs || !owner);
    assign bus.grant_d = owner;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign bus.i_err = 1'b0;
    assign bus.d_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            owner              <= 1'b0;
            bus.ext_mem_addr   <= '0;
            bus.ext_mem_data_o <= '0;
            bus.ext_mem_cs     <= 1'b0;
            bus.ext_mem_we     <= 1'b0;
            bus.i_data_o       <= '0;
            bus.d_data_o       <= '0;
            bus.i_ack          <= 1'b0;
            bus.d_ack          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus.i_err          <= 1'b0;
            bus.d_err          <= 1'b0;
            cnt                <= '0;
`endif
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus.i_err <= 1'b0;
            bus.d_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.i_cs || bus.d_cs) begin
                        owner              <= sel_d;
                        bus.ext_mem_addr   <= sel_d ? bus.d_addr   : bus.i_addr;
                        bus.ext_mem_data_o <= sel_d ? bus.d_data_i : bus.i_data_i;
                        bus.ext_mem_we     <= sel_d ? bus.d_we     : bus.i_we;
                        bus.ext_mem_cs     <= 1'b1;
                        state              <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt                <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (bus.ext_mem_ack) begin
                        if (owner) begin
                            bus.d_data_o <= bus.ext_mem_data_i;
                            bus.d_ack    <= 1'b1;
                        end else begin
                            bus.i_data_o <= bus.ext_mem_data_i;
                            bus.i_ack    <= 1'b1;
                        end
                        bus.ext_mem_cs <= 1'b0;
                        bus.ext_mem_we <= 1'b0;
                        state          <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Memory never answered: abort and report an errored completion.
                    else if (timed_out) begin
                        if (owner) begin
                            bus.d_data_o <= '0;
                            bus.d_ack    <= 1'b1;
                            bus.d_err    <= 1'b1;
                        end else begin
                            bus.i_data_o <= '0;
                            bus.i_ack    <= 1'b1;
                            bus.i_err    <= 1'b1;
                        end
                        bus.ext_mem_cs <= 1'b0;
                        bus.ext_mem_we <= 1'b0;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written
// sequences for zero-wait memory, reset during BUSY and the watchdog (MEM_ARB_TIMEOUT_EN).
module tb_mem_arbiter;

    typedef struct {
        logic         i_cs;
        logic         i_we;
        logic [31:0]  i_addr;
        logic [255:0] i_wd;
        logic         d_cs;
        logic         d_we;
        logic [31:0]  d_addr;
        logic [255:0] d_wd;
        int           lat;
        logic [255:0] rdata;
        logic         exp_gd;
        logic [31:0]  exp_addr;
        logic         exp_we;
        logic [255:0] exp_wd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    logic [255:0] exp_i_do;
    logic [255:0] exp_d_do;
    vec_t vecs [8];
    vec_t post_rst;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus ();

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at 1 time unit into an IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        bus.i_cs = v.i_cs; bus.i_we = v.i_we; bus.i_addr = v.i_addr; bus.i_data_i = v.i_wd;
        bus.d_cs = v.d_cs; bus.d_we = v.d_we; bus.d_addr = v.d_addr; bus.d_data_i = v.d_wd;
        tick();
        check($sformatf("v%0d_grant_d", idx), bus.grant_d, v.exp_gd);
        check($sformatf("v%0d_we", idx), bus.ext_mem_we, v.exp_we);
        check($sformatf("v%0d_wdata", idx), bus.ext_mem_data_o, v.exp_wd);
        for (int k = 1; k <= v.lat; k++) begin
            check($sformatf("v%0d_busy%0d_cs", idx, k), bus.ext_mem_cs, 1'b1);
            check($sformatf("v%0d_busy%0d_addr", idx, k), bus.ext_mem_addr, v.exp_addr);
            check($sformatf("v%0d_busy%0d_acks", idx, k), {bus.i_ack, bus.d_ack}, 2'b00);
            if (k == v.lat) begin
                bus.ext_mem_ack    = 1'b1;
                bus.ext_mem_data_i = v.rdata;
            end
            tick();
        end
        bus.ext_mem_ack    = 1'b0;
        bus.ext_mem_data_i = ~v.rdata;
        check($sformatf("v%0d_resp_cs", idx), bus.ext_mem_cs, 1'b0);
        check($sformatf("v%0d_resp_we", idx), bus.ext_mem_we, 1'b0);
        check($sformatf("v%0d_resp_i_ack", idx), bus.i_ack, !v.exp_gd);
        check($sformatf("v%0d_resp_d_ack", idx), bus.d_ack, v.exp_gd);
        check($sformatf("v%0d_resp_err", idx), {bus.i_err, bus.d_err}, 2'b00);
        if (v.exp_gd) exp_d_do = v.rdata;
        else          exp_i_do = v.rdata;
        check($sformatf("v%0d_resp_i_data", idx), bus.i_data_o, exp_i_do);
        check($sformatf("v%0d_resp_d_data", idx), bus.d_data_o, exp_d_do);
        bus.i_cs = 1'b0;
        bus.d_cs = 1'b0;
        tick();
        check($sformatf("v%0d_idle_acks", idx), {bus.i_ack, bus.d_ack}, 2'b00);
        check($sformatf("v%0d_idle_grant_d", idx), bus.grant_d, v.exp_gd);
        check($sformatf("v%0d_idle_data", idx), {bus.i_data_o, bus.d_data_o}, {exp_i_do, exp_d_do});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy;
        clk = 1'b0; rst_n = 1'b0; n_cmp = 0; n_fail = 0;
        exp_i_do = '0; exp_d_do = '0;
        bus.i_cs = 0; bus.i_we = 0; bus.i_addr = '0; bus.i_data_i = '0;
        bus.d_cs = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_data_i = '0;
        bus.ext_mem_ack = 0; bus.ext_mem_data_i = '0;

        // inputs: i_cs,i_we,i_addr,i_wd, d_cs,d_we,d_addr,d_wd, lat,rdata | expect gd,addr,we,wdata
        vecs[0] = '{1, 0, 32'h200, 256'h1100, 1, 0, 32'h300, 256'h2200, 2, 256'hC0DE0, 1, 32'h300, 0, 256'h2200};
        vecs[1] = '{1, 0, 32'h201, 256'h1101, 1, 0, 32'h301, 256'h2201, 2, 256'hC0DE1, 0, 32'h201, 0, 256'h1101};
        vecs[2] = '{1, 0, 32'h202, 256'h1102, 1, 0, 32'h302, 256'h2202, 2, 256'hC0DE2, 1, 32'h302, 0, 256'h2202};
        vecs[3] = '{1, 0, 32'h203, 256'h1103, 1, 0, 32'h303, 256'h2203, 2, 256'hC0DE3, 0, 32'h203, 0, 256'h1103};
        vecs[4] = '{0, 0, 32'h000, 256'h0, 1, 0, 32'h100, 256'hBEEF, 3, {32{8'hA5}}, 1, 32'h100, 0, 256'hBEEF};
        vecs[5] = '{1, 1, 32'h040, 256'h1234, 0, 0, 32'h000, 256'h0, 2, 256'hDEAD, 0, 32'h040, 1, 256'h1234};
        vecs[6] = '{0, 0, 32'h000, 256'h0, 1, 1, 32'h080, {8{32'h55AA_33CC}}, 1, 256'h7, 1, 32'h080, 1, {8{32'h55AA_33CC}}};
        vecs[7] = '{1, 0, 32'h500, 256'h9, 1, 1, 32'h600, 256'hA, 4, 256'hFACE, 0, 32'h500, 0, 256'h9};
        post_rst = '{1, 0, 32'h210, 256'h3, 1, 0, 32'h310, 256'h4, 2, 256'h77, 1, 32'h310, 0, 256'h4};

        #1;
        check("rst_cs_we", {bus.ext_mem_cs, bus.ext_mem_we}, 2'b00);
        check("rst_acks_errs", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 4'b0000);
        check("rst_data_o", {bus.i_data_o, bus.d_data_o}, 512'h0);
        check("rst_mem_regs", {bus.ext_mem_addr, bus.ext_mem_data_o}, 288'h0);
        check("rst_grant_d", bus.grant_d, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Zero-wait memory with the D-side requesting continuously: one grant every 3 cycles.
        bus.ext_mem_ack = 1'b1; bus.ext_mem_data_i = 256'h5A;
        bus.d_cs = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h440;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("zw%0d_cs", k), bus.ext_mem_cs, (k % 3) == 1);
            check($sformatf("zw%0d_d_ack", k), bus.d_ack, (k % 3) == 2);
        end
        bus.d_cs = 1'b0; bus.ext_mem_ack = 1'b0;
        exp_d_do = 256'h5A;
        check("zw_d_data", bus.d_data_o, exp_d_do);
        check("zw_i_ack", bus.i_ack, 1'b0);
        tick();

        // Reset asserted while BUSY.
        bus.d_cs = 1'b1; bus.d_addr = 32'h700;
        tick();
        check("rb_busy_cs", bus.ext_mem_cs, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_cs_async", bus.ext_mem_cs, 1'b0);
        check("rb_data_cleared", {bus.i_data_o, bus.d_data_o}, 512'h0);
        check("rb_grant_d", bus.grant_d, 1'b0);
        exp_i_do = '0; exp_d_do = '0;
        bus.d_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.ext_mem_ack = 1'b1; bus.ext_mem_data_i = 256'hBAD;
        tick();
        check("rb_stray1", {bus.i_ack, bus.d_ack, bus.ext_mem_cs}, 3'b000);
        tick();
        check("rb_stray2", {bus.i_ack, bus.d_ack, bus.ext_mem_cs}, 3'b000);
        bus.ext_mem_ack = 1'b0;
        run_vec(post_rst, 8);

        // Memory that never acknowledges.
        bus.d_cs = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h900;
        busy = 0;
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        while (bus.ext_mem_cs && busy < 20) begin
            busy++;
            tick();
        end
        check("to_busy_cycles", busy, 8);
        check("to_d_ack", bus.d_ack, 1'b1);
        check("to_d_err", bus.d_err, 1'b1);
        check("to_d_data", bus.d_data_o, 256'h0);
        check("to_i_ack", bus.i_ack, 1'b0);
        bus.d_cs = 1'b0;
        tick();
        check("to_after", {bus.d_ack, bus.d_err}, 2'b00);
`else
        for (int k = 0; k < 100; k++) begin
            if (bus.ext_mem_cs && !bus.d_ack && !bus.d_err) busy++;
            tick();
        end
        check("nto_busy_cycles", busy, 100);
        check("nto_cs_still", bus.ext_mem_cs, 1'b1);
        bus.d_cs = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
